// File: rtl/pc_gen.sv
// ---------------------------------------------------------------------------
// PcGen -- fetch program-counter generator with an optional return-address
// stack.
//
// Chooses the next fetch address from a fixed priority of redirect sources:
// branch mispredict, resolved JALR, decoded JAL, RAS-predicted return,
// predicted-taken branch, then sequential pc + 4.
//
// Optional feature macro: RV6_PC_RAS_EN
//   defined   -> a circular return-address stack is built; ras_pop can
//                redirect to the stack top and ras_hit/ras_cnt are live.
//   undefined -> no RAS storage; ras_push/ras_pop/ras_flush are ignored and
//                ras_hit/ras_cnt are tied to zero.
//
// Ports:
//   clk                       rising-edge clock for all state
//   rst                       asynchronous active-high reset
//   pc            [XLEN]      registered fetch address
//   stall                     freezes all state and ignores every request
//   pr_miss/br_addr           mispredict redirect and target
//   jalr_taken/jalr_addr      resolved JALR redirect and target
//   jal_taken/jal_addr        decoded JAL redirect and target
//   pr_taken/pr_offs          predicted-taken branch, signed offset from pc
//   ras_push/ras_push_addr    call detected, return address to remember
//   ras_pop                   return detected, asks for a RAS redirect
//   ras_flush                 empties the RAS
//   ras_hit                   one cycle after a RAS redirect was applied
//   ras_cnt                   number of valid RAS entries
// ---------------------------------------------------------------------------
module pc_gen #(
    parameter int          XLEN         = 64,
    parameter logic [63:0] RESET_VECTOR = 64'h80000000,
    parameter int          BOFFS_W      = 13,
    parameter int          RAS_DEPTH    = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    output logic [XLEN-1:0]                pc,
    input  logic                           stall,
    input  logic                           pr_miss,
    input  logic [XLEN-1:0]                br_addr,
    input  logic                           jalr_taken,
    input  logic [XLEN-1:0]                jalr_addr,
    input  logic                           jal_taken,
    input  logic [XLEN-1:0]                jal_addr,
    input  logic                           pr_taken,
    input  logic [BOFFS_W-1:0]             pr_offs,
    input  logic                           ras_push,
    input  logic [XLEN-1:0]                ras_push_addr,
    input  logic                           ras_pop,
    input  logic                           ras_flush,
    output logic                           ras_hit,
    output logic [$clog2(RAS_DEPTH):0]     ras_cnt
);

    localparam int              CNT_W    = $clog2(RAS_DEPTH) + 1;
    localparam logic [XLEN-1:0] RESET_PC = RESET_VECTOR[XLEN-1:0];

    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_d;
    logic [XLEN-1:0] offs_sext;
    logic            ras_redirect;
    logic [XLEN-1:0] ras_target;

    assign offs_sext = {{(XLEN-BOFFS_W){pr_offs[BOFFS_W-1]}}, pr_offs};

`ifdef RV6_PC_RAS_EN
    localparam int PTR_W = $clog2(RAS_DEPTH);

    logic [XLEN-1:0]  ras_mem [RAS_DEPTH];
    logic [PTR_W-1:0] top_q;
    logic [PTR_W-1:0] top_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             hit_q;
    logic             wr_en;
    logic [PTR_W-1:0] wr_ptr;

    // A pop only counts when the stack holds something, no flush is asking
    // to empty it and no architectural redirect outranks the prediction.
    assign ras_redirect = ras_pop && (cnt_q != '0) && !ras_flush
                          && !pr_miss && !jalr_taken && !jal_taken;
    assign ras_target   = ras_mem[top_q];

    // Stack bookkeeping. A pop+push in the same cycle reuses the slot just
    // consumed, so pointer and count stay put. Pointer arithmetic wraps, so
    // a push into a full stack silently overwrites the oldest entry.
    always_comb begin
        top_d  = top_q;
        cnt_d  = cnt_q;
        wr_en  = 1'b0;
        wr_ptr = top_q;
        if (ras_flush) begin
            top_d = '0;
            cnt_d = '0;
        end else if (ras_redirect && ras_push) begin
            wr_en  = 1'b1;
            wr_ptr = top_q;
        end else if (ras_redirect) begin
            top_d = top_q - PTR_W'(1);
            cnt_d = cnt_q - CNT_W'(1);
        end else if (ras_push) begin
            top_d  = top_q + PTR_W'(1);
            wr_en  = 1'b1;
            wr_ptr = top_q + PTR_W'(1);
            if (cnt_q != CNT_W'(RAS_DEPTH)) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // Stack control state; everything freezes while stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            top_q <= '0;
            cnt_q <= '0;
            hit_q <= 1'b0;
        end else if (!stall) begin
            top_q <= top_d;
            cnt_q <= cnt_d;
            hit_q <= ras_redirect;
        end
    end

    // Entry storage carries no reset; validity is tracked by the count.
    always_ff @(posedge clk) begin
        if (!stall && wr_en) begin
            ras_mem[wr_ptr] <= ras_push_addr;
        end
    end

    assign ras_hit = hit_q;
    assign ras_cnt = cnt_q;
`else
    logic unused_ras;

    assign ras_redirect = 1'b0;
    assign ras_target   = '0;
    assign ras_hit      = 1'b0;
    assign ras_cnt      = '0;
    assign unused_ras   = ^{ras_push, ras_push_addr, ras_pop, ras_flush};
`endif

    // Next-pc priority mux.
    always_comb begin
        pc_d = pc_q + XLEN'(4);
        if (pr_miss) begin
            pc_d = br_addr;
        end else if (jalr_taken) begin
            pc_d = jalr_addr;
        end else if (jal_taken) begin
            pc_d = jal_addr;
        end else if (ras_redirect) begin
            pc_d = ras_target;
        end else if (pr_taken) begin
            pc_d = pc_q + offs_sext;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q <= RESET_PC;
        end else if (!stall) begin
            pc_q <= pc_d;
        end
    end

    assign pc = pc_q;

endmodule

// File: tb/tb_pc_gen.sv
// ---------------------------------------------------------------------------
// tb_pc_gen -- self-checking bench for pc_gen.
// Directed scenarios plus a randomized run, all compared against a
// queue-based reference model of the fetch address and return stack.
// Follows the RV6_PC_RAS_EN macro the same way the design does.
// ---------------------------------------------------------------------------
module tb_pc_gen;

    localparam int          XLEN  = 64;
    localparam logic [63:0] RV    = 64'h80000000;
    localparam int          BW    = 13;
    localparam int          DEPTH = 4;
    localparam int          CW    = $clog2(DEPTH) + 1;
`ifdef RV6_PC_RAS_EN
    localparam bit RAS_EN = 1'b1;
`else
    localparam bit RAS_EN = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic [XLEN-1:0] pc;
    logic            stall;
    logic            pr_miss;
    logic [XLEN-1:0] br_addr;
    logic            jalr_taken;
    logic [XLEN-1:0] jalr_addr;
    logic            jal_taken;
    logic [XLEN-1:0] jal_addr;
    logic            pr_taken;
    logic [BW-1:0]   pr_offs;
    logic            ras_push;
    logic [XLEN-1:0] ras_push_addr;
    logic            ras_pop;
    logic            ras_flush;
    logic            ras_hit;
    logic [CW-1:0]   ras_cnt;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [63:0] m_pc;
    logic [63:0] m_ras[$];
    bit          m_hit;

    pc_gen #(
        .XLEN(XLEN), .RESET_VECTOR(RV), .BOFFS_W(BW), .RAS_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst(rst), .pc(pc), .stall(stall),
        .pr_miss(pr_miss), .br_addr(br_addr),
        .jalr_taken(jalr_taken), .jalr_addr(jalr_addr),
        .jal_taken(jal_taken), .jal_addr(jal_addr),
        .pr_taken(pr_taken), .pr_offs(pr_offs),
        .ras_push(ras_push), .ras_push_addr(ras_push_addr),
        .ras_pop(ras_pop), .ras_flush(ras_flush),
        .ras_hit(ras_hit), .ras_cnt(ras_cnt)
    );

    always #5 clk = ~clk;

    task automatic clear_inputs;
        stall = 0; pr_miss = 0; br_addr = '0; jalr_taken = 0; jalr_addr = '0;
        jal_taken = 0; jal_addr = '0; pr_taken = 0; pr_offs = '0;
        ras_push = 0; ras_push_addr = '0; ras_pop = 0; ras_flush = 0;
    endtask

    task automatic model_reset;
        m_pc = RV;
        m_ras.delete();
        m_hit = 0;
    endtask

    // Advance the model from the current inputs, then clock the DUT and
    // settle just after the edge.
    task automatic step;
        logic [63:0] n_pc;
        longint      off;
        bit          eff;
        if (!stall) begin
            eff = RAS_EN && ras_pop && !ras_flush && (m_ras.size() > 0)
                  && !pr_miss && !jalr_taken && !jal_taken;
            off = longint'($signed(pr_offs));
            if (pr_miss)         n_pc = br_addr;
            else if (jalr_taken) n_pc = jalr_addr;
            else if (jal_taken)  n_pc = jal_addr;
            else if (eff)        n_pc = m_ras[$];
            else if (pr_taken)   n_pc = m_pc + 64'(off);
            else                 n_pc = m_pc + 64'd4;
            if (RAS_EN) begin
                if (ras_flush) begin
                    m_ras.delete();
                end else if (eff && ras_push) begin
                    m_ras[m_ras.size()-1] = ras_push_addr;
                end else if (eff) begin
                    void'(m_ras.pop_back());
                end else if (ras_push) begin
                    m_ras.push_back(ras_push_addr);
                    if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
                end
            end
            m_pc  = n_pc;
            m_hit = eff;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1;
        clear_inputs();
        stall = 1;
        #2;
        checks++;
        if (pc !== RV) begin errors++; $display("[TB] FAIL reset_pc: got %h expected %h", pc, RV); end
        checks++;
        if (ras_cnt !== '0) begin errors++; $display("[TB] FAIL reset_cnt: got %0d expected 0", ras_cnt); end
        checks++;
        if (ras_hit !== 1'b0) begin errors++; $display("[TB] FAIL reset_hit: got %0b expected 0", ras_hit); end
        stall = 0;
        pr_miss = 1; br_addr = 64'h1234;
        @(posedge clk); #1;
        checks++;
        if (pc !== RV) begin errors++; $display("[TB] FAIL reset_hold_pc: got %h expected %h", pc, RV); end
        clear_inputs();
        rst = 0;
        model_reset();
    endtask

    task automatic test_sequential;
        logic [63:0] exp [3];
        exp[0] = 64'h80000004; exp[1] = 64'h80000008; exp[2] = 64'h8000000C;
        clear_inputs();
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (pc !== exp[i]) begin errors++; $display("[TB] FAIL seq_pc%0d: got %h expected %h", i, pc, exp[i]); end
        end
    endtask

    task automatic test_priority;
        clear_inputs();
        pr_miss = 1; br_addr = 64'h100;
        jalr_taken = 1; jalr_addr = 64'h200;
        jal_taken = 1; jal_addr = 64'h300;
        pr_taken = 1; pr_offs = 13'h0040;
        step();
        checks++;
        if (pc !== 64'h100) begin errors++; $display("[TB] FAIL prio_miss: got %h expected %h", pc, 64'h100); end
        stall = 1; br_addr = 64'h900;
        step();
        checks++;
        if (pc !== 64'h100) begin errors++; $display("[TB] FAIL prio_stall: got %h expected %h", pc, 64'h100); end
        stall = 0; pr_miss = 0;
        step();
        checks++;
        if (pc !== 64'h200) begin errors++; $display("[TB] FAIL prio_jalr: got %h expected %h", pc, 64'h200); end
        jalr_taken = 0;
        step();
        checks++;
        if (pc !== 64'h300) begin errors++; $display("[TB] FAIL prio_jal: got %h expected %h", pc, 64'h300); end
        jal_taken = 0;
        step();
        checks++;
        if (pc !== 64'h340) begin errors++; $display("[TB] FAIL prio_prtaken: got %h expected %h", pc, 64'h340); end
    endtask

    task automatic test_branch_offset;
        clear_inputs();
        jal_taken = 1; jal_addr = 64'h80000010;
        step();
        clear_inputs();
        pr_taken = 1; pr_offs = 13'h1FF8;
        step();
        checks++;
        if (pc !== 64'h80000008) begin errors++; $display("[TB] FAIL offs_neg: got %h expected %h", pc, 64'h80000008); end
        pr_offs = 13'h0FFC;
        step();
        checks++;
        if (pc !== 64'h80001004) begin errors++; $display("[TB] FAIL offs_pos: got %h expected %h", pc, 64'h80001004); end
        clear_inputs();
        jal_taken = 1; jal_addr = 64'hFFFFFFFFFFFFFFFC;
        step();
        clear_inputs();
        step();
        checks++;
        if (pc !== 64'h0) begin errors++; $display("[TB] FAIL wrap_pc: got %h expected 0", pc); end
    endtask

`ifdef RV6_PC_RAS_EN
    task automatic test_ras_basic;
        clear_inputs();
        ras_push = 1; ras_push_addr = 64'hA0;
        step();
        checks++;
        if (ras_cnt !== CW'(1)) begin errors++; $display("[TB] FAIL ras_cnt_push1: got %0d expected 1", ras_cnt); end
        ras_push_addr = 64'hB0;
        step();
        checks++;
        if (ras_cnt !== CW'(2)) begin errors++; $display("[TB] FAIL ras_cnt_push2: got %0d expected 2", ras_cnt); end
        clear_inputs();
        ras_pop = 1;
        step();
        checks++;
        if (pc !== 64'hB0) begin errors++; $display("[TB] FAIL ras_pop1_pc: got %h expected b0", pc); end
        checks++;
        if (ras_hit !== 1'b1 || ras_cnt !== CW'(1)) begin errors++; $display("[TB] FAIL ras_pop1_state: got hit %0b cnt %0d expected hit 1 cnt 1", ras_hit, ras_cnt); end
        step();
        checks++;
        if (pc !== 64'hA0) begin errors++; $display("[TB] FAIL ras_pop2_pc: got %h expected a0", pc); end
        checks++;
        if (ras_hit !== 1'b1 || ras_cnt !== CW'(0)) begin errors++; $display("[TB] FAIL ras_pop2_state: got hit %0b cnt %0d expected hit 1 cnt 0", ras_hit, ras_cnt); end
        step();
        checks++;
        if (pc !== 64'hA4 || ras_hit !== 1'b0) begin errors++; $display("[TB] FAIL ras_pop_empty: got pc %h hit %0b expected pc a4 hit 0", pc, ras_hit); end
    endtask

    task automatic test_ras_overflow;
        logic [63:0] exp [4];
        exp[0] = 64'h50; exp[1] = 64'h40; exp[2] = 64'h30; exp[3] = 64'h20;
        clear_inputs();
        ras_push = 1;
        for (int k = 1; k <= 5; k++) begin
            ras_push_addr = 64'(k * 16);
            step();
        end
        checks++;
        if (ras_cnt !== CW'(DEPTH)) begin errors++; $display("[TB] FAIL ovf_cnt: got %0d expected %0d", ras_cnt, DEPTH); end
        clear_inputs();
        ras_pop = 1;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (pc !== exp[i] || ras_hit !== 1'b1) begin errors++; $display("[TB] FAIL ovf_pop%0d: got pc %h hit %0b expected pc %h hit 1", i, pc, ras_hit, exp[i]); end
        end
        step();
        checks++;
        if (pc !== 64'h24 || ras_hit !== 1'b0) begin errors++; $display("[TB] FAIL ovf_fallthru: got pc %h hit %0b expected pc 24 hit 0", pc, ras_hit); end
    endtask

    task automatic test_ras_push_pop;
        clear_inputs();
        ras_push = 1; ras_push_addr = 64'hD0;
        step();
        ras_push_addr = 64'hE0;
        step();
        ras_push_addr = 64'hC0; ras_pop = 1;
        step();
        checks++;
        if (pc !== 64'hE0 || ras_cnt !== CW'(2) || ras_hit !== 1'b1) begin errors++; $display("[TB] FAIL pushpop: got pc %h cnt %0d hit %0b expected pc e0 cnt 2 hit 1", pc, ras_cnt, ras_hit); end
        clear_inputs();
        ras_pop = 1;
        step();
        checks++;
        if (pc !== 64'hC0 || ras_cnt !== CW'(1)) begin errors++; $display("[TB] FAIL pushpop_next: got pc %h cnt %0d expected pc c0 cnt 1", pc, ras_cnt); end
        pr_miss = 1; br_addr = 64'h400;
        step();
        checks++;
        if (pc !== 64'h400 || ras_cnt !== CW'(1) || ras_hit !== 1'b0) begin errors++; $display("[TB] FAIL pop_outranked: got pc %h cnt %0d hit %0b expected pc 400 cnt 1 hit 0", pc, ras_cnt, ras_hit); end
        clear_inputs();
        ras_flush = 1; ras_pop = 1; ras_push = 1; ras_push_addr = 64'h777;
        step();
        checks++;
        if (pc !== 64'h404 || ras_cnt !== CW'(0) || ras_hit !== 1'b0) begin errors++; $display("[TB] FAIL flush: got pc %h cnt %0d hit %0b expected pc 404 cnt 0 hit 0", pc, ras_cnt, ras_hit); end
        clear_inputs();
        stall = 1; ras_push = 1; ras_push_addr = 64'h88;
        step();
        checks++;
        if (pc !== 64'h404 || ras_cnt !== CW'(0)) begin errors++; $display("[TB] FAIL stall_push: got pc %h cnt %0d expected pc 404 cnt 0", pc, ras_cnt); end
    endtask

    task automatic test_ras_async_reset;
        clear_inputs();
        ras_push = 1; ras_push_addr = 64'h70;
        step();
        ras_push_addr = 64'h80;
        step();
        clear_inputs();
        ras_pop = 1;
        step();
        #2;
        rst = 1;
        #1;
        checks++;
        if (pc !== RV || ras_cnt !== CW'(0) || ras_hit !== 1'b0) begin errors++; $display("[TB] FAIL async_rst: got pc %h cnt %0d hit %0b expected pc %h cnt 0 hit 0", pc, ras_cnt, ras_hit, RV); end
        model_reset();
        @(posedge clk); #1;
        rst = 0;
        step();
        checks++;
        if (pc !== RV + 64'd4 || ras_hit !== 1'b0 || ras_cnt !== CW'(0)) begin errors++; $display("[TB] FAIL post_rst: got pc %h hit %0b cnt %0d expected pc %h hit 0 cnt 0", pc, ras_hit, ras_cnt, RV + 64'd4); end
        clear_inputs();
    endtask
`else
    task automatic test_ras_disabled;
        clear_inputs();
        ras_push = 1; ras_push_addr = 64'hA0;
        step();
        ras_push_addr = 64'hB0; ras_pop = 1;
        step();
        checks++;
        if (pc !== m_pc) begin errors++; $display("[TB] FAIL noras_pc: got %h expected %h", pc, m_pc); end
        checks++;
        if (ras_cnt !== '0 || ras_hit !== 1'b0) begin errors++; $display("[TB] FAIL noras_outputs: got cnt %0d hit %0b expected 0 0", ras_cnt, ras_hit); end
        ras_push = 0;
        step();
        checks++;
        if (pc !== m_pc || ras_hit !== 1'b0) begin errors++; $display("[TB] FAIL noras_pop: got pc %h hit %0b expected pc %h hit 0", pc, ras_hit, m_pc); end
    endtask
`endif

    task automatic test_random;
        for (int i = 0; i < 400; i++) begin
            stall         = ($urandom_range(7) == 0);
            pr_miss       = ($urandom_range(15) == 0);
            br_addr       = {$urandom, $urandom} & ~64'h3;
            jalr_taken    = ($urandom_range(15) == 0);
            jalr_addr     = {$urandom, $urandom} & ~64'h3;
            jal_taken     = ($urandom_range(11) == 0);
            jal_addr      = {$urandom, $urandom} & ~64'h3;
            pr_taken      = ($urandom_range(3) == 0);
            pr_offs       = BW'($urandom);
            ras_push      = ($urandom_range(3) == 0);
            ras_push_addr = {$urandom, $urandom} & ~64'h3;
            ras_pop       = ($urandom_range(2) == 0);
            ras_flush     = ($urandom_range(31) == 0);
            step();
            checks++;
            if (pc !== m_pc) begin errors++; $display("[TB] FAIL rand_pc@%0d: got %h expected %h", i, pc, m_pc); end
            checks++;
            if (ras_cnt !== CW'(m_ras.size())) begin errors++; $display("[TB] FAIL rand_cnt@%0d: got %0d expected %0d", i, ras_cnt, m_ras.size()); end
            checks++;
            if (ras_hit !== m_hit) begin errors++; $display("[TB] FAIL rand_hit@%0d: got %0b expected %0b", i, ras_hit, m_hit); end
        end
        clear_inputs();
    endtask

    initial begin
        $display("[TB] pc_gen bench start, RAS enabled = %0b", RAS_EN);
        test_reset();
        test_sequential();
        test_priority();
        test_branch_offset();
`ifdef RV6_PC_RAS_EN
        test_ras_basic();
        test_ras_overflow();
        test_ras_push_pop();
        test_ras_async_reset();
`else
        test_ras_disabled();
`endif
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_gen.md
PC_GEN -- requirements
Module: pc_gen

Interface
REQ-001 Parameter XLEN, 64, PC and address width in bits.
REQ-002 Parameter RESET_VECTOR, 64'h80000000, PC value loaded on reset, truncated to XLEN.
REQ-003 Parameter BOFFS_W, 13, width of the signed predicted-branch offset.
REQ-004 Parameter RAS_DEPTH, 8, return-address-stack entries; power of two, at least 2.
REQ-005 Port clk, input, 1, rising-edge clock for all state.
REQ-006 Port rst, input, 1, asynchronous active-high reset for all state.
REQ-007 Port pc, output, XLEN, current fetch address (registered).
REQ-008 Port stall, input, 1, holds all state when high.
REQ-009 Port pr_miss / br_addr, input, 1 / XLEN, branch mispredict redirect and its target.
REQ-010 Port jalr_taken / jalr_addr, input, 1 / XLEN, resolved JALR redirect and its target.
REQ-011 Port jal_taken / jal_addr, input, 1 / XLEN, decoded JAL redirect and its target.
REQ-012 Port pr_taken / pr_offs, input, 1 / BOFFS_W, predicted-taken branch and its signed offset relative to pc.
REQ-013 Port ras_push / ras_push_addr, input, 1 / XLEN, call detected and its return address.
REQ-014 Port ras_pop, input, 1, return instruction detected at pc; requests a RAS-predicted redirect.
REQ-015 Port ras_flush, input, 1, empties the RAS.
REQ-016 Port ras_hit, output, 1, registered; high for one cycle after a RAS-predicted redirect was applied.
REQ-017 Port ras_cnt, output, $clog2(RAS_DEPTH)+1, registered; number of valid RAS entries.

Function
REQ-018 When stall=0, pc SHALL update at the rising edge of clk by the first matching source in this order: pr_miss -> br_addr; jalr_taken -> jalr_addr; jal_taken -> jal_addr; ras_pop with ras_cnt>0 -> RAS top; pr_taken -> pc + sext(pr_offs); otherwise pc + 4.
REQ-019 The sext(pr_offs) result SHALL be sign-extended to XLEN, and all additions SHALL wrap modulo 2^XLEN.
REQ-020 When stall=1, pc, the RAS contents, ras_cnt and ras_hit SHALL hold their values, and all inputs SHALL be ignored.
REQ-021 The RAS SHALL be a circular buffer with a top pointer and a saturating count.
REQ-022 A push SHALL write ras_push_addr at top+1, advance top, and increment ras_cnt, saturating at RAS_DEPTH.
REQ-023 A push while full SHALL overwrite the oldest entry (wrap-around), and ras_cnt SHALL stay at RAS_DEPTH.
REQ-024 A pop SHALL take effect only when ras_pop=1, ras_cnt>0 and no higher-priority redirect is active; it SHALL decrement top and ras_cnt.
REQ-025 A ras_pop while ras_cnt=0 SHALL be ignored; pc SHALL fall through to the next priority and ras_hit SHALL be 0.
REQ-026 ras_push SHALL be honoured regardless of which pc source wins.
REQ-027 A simultaneous effective pop and push SHALL redirect to the old top, write ras_push_addr into the same slot, and leave ras_cnt unchanged.
REQ-028 ras_flush SHALL set ras_cnt to 0 at the next edge, take priority over a same-cycle push and pop, and leave pc selection unaffected except that no RAS redirect occurs in that cycle.
REQ-029 ras_hit SHALL be 1 for exactly the cycle after an effective pop, and 0 otherwise.

Reset
REQ-030 While rst=1: pc=RESET_VECTOR, ras_cnt=0, top=0, ras_hit=0, regardless of clk or stall.
REQ-031 Reset asserted mid-operation SHALL discard the RAS contents immediately; the first edge after rst falls SHALL produce RESET_VECTOR+4 (absent other requests).
REQ-032 RAS entry storage need not be reset.

Configuration
REQ-033 With macro RV6_PC_RAS_EN defined: the RAS, ras_pop, ras_hit and ras_cnt behave as above.
REQ-034 Without RV6_PC_RAS_EN: no RAS storage is built; ras_push, ras_pop and ras_flush are ignored; ras_hit and ras_cnt are tied to 0; the priority is pr_miss, jalr, jal, pr_taken, +4.

Verification
REQ-035 Reset release, no requests, 3 edges -> pc 0x80000000, 0x80000004, 0x80000008, 0x8000000C.
REQ-036 pr_miss=1 (br_addr=0x100), jalr_taken=1 (0x200) and jal_taken=1 (0x300) together -> pc=0x100; with stall=1 -> pc unchanged.
REQ-037 pc=0x80000010, pr_taken, pr_offs=13'h1FF8 (-8) -> pc=0x80000008.
REQ-038 Push 0xA0, 0xB0, then pop, pop -> pc=0xB0 then 0xA0; ras_hit=1 on each following cycle; ras_cnt 2->1->0; third pop -> pc+4, ras_hit=0.
REQ-039 RAS_DEPTH=4: push 0x10..0x50 (5 pushes) -> ras_cnt=4; 4 pops return 0x50, 0x40, 0x30, 0x20; fifth pop falls through.
REQ-040 ras_cnt=2 with push 0xC0 and pop in the same cycle -> pc=old top, ras_cnt=2, next pop -> 0xC0; rst pulsed mid-sequence -> ras_cnt=0 and pc=0x80000000 asynchronously.
